// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART core: register map, FSM state
// encodings and bit positions within STATUS, ERR and INTR registers.
package uart_pkg;

   localparam logic [7:0] ADDR_CTRL       = 8'h00;
   localparam logic [7:0] ADDR_TXDATA     = 8'h04;
   localparam logic [7:0] ADDR_RXDATA     = 8'h08;
   localparam logic [7:0] ADDR_STATUS     = 8'h0C;
   localparam logic [7:0] ADDR_INTR_EN    = 8'h10;
   localparam logic [7:0] ADDR_INTR_STATE = 8'h14;
   localparam logic [7:0] ADDR_ERR        = 8'h18;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_EVEN  = 2'b01,
      PAR_ODD   = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_e;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_TX_BUSY  = 4;

   localparam int ERR_RX_OVF = 0;
   localparam int ERR_FRAME  = 1;
   localparam int ERR_PARITY = 2;
   localparam int ERR_TX_OVF = 3;

   localparam int INTR_TX  = 0;
   localparam int INTR_RX  = 1;
   localparam int INTR_ERR = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with combinational head output (0 when empty).
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push, do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr_reg];
   assign level   = count_reg;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
         else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, runtime divisor, optional parity and
// maskable interrupts behind a simple ren/we register bus.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int          DATA_BITS  = 8,
   parameter int          STOP_BITS  = 1,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ren,
   input  logic        we,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        intr_tx,
   output logic        intr_rx,
   output logic        intr_err
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                 tx_en_reg, rx_en_reg;
   parity_e              parity_reg;
   logic [7:0]           wm_reg;
   logic [15:0]          div_reg, div_eff;
   logic [2:0]           ien_reg, istate_reg;
   logic [3:0]           err_reg;

   logic                 tx_full, tx_empty, tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_head;
   logic [LW-1:0]        tx_level;
   logic                 rx_full, rx_empty, rx_push, rx_pop;
   logic [DATA_BITS-1:0] rx_head;
   logic [LW-1:0]        rx_level;

   tx_state_e            tx_state_reg;
   logic [15:0]          tx_cnt_reg, tx_div_reg;
   logic [DATA_BITS-1:0] tx_shift_reg;
   logic [2:0]           tx_bit_reg;
   logic                 tx_stop_reg, tx_par_en_reg, tx_par_bit_reg;
   logic                 tx_bit_end, tx_stop_last, tx_load, tx_evt;

   rx_state_e            rx_state_reg;
   logic                 rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
   logic [15:0]          rx_cnt_reg, rx_div_reg;
   logic [DATA_BITS-1:0] rx_shift_reg;
   logic [2:0]           rx_bit_reg;
   logic                 rx_par_en_reg, rx_par_odd_reg, rx_par_err_reg;
   logic                 rx_sample, rx_stop_sample, rx_pop_ok, rx_push_ok, rx_evt;
   logic [8:0]           rx_level_after;
   logic [3:0]           err_set;
   logic                 par_en, par_odd, unused_bits;

   assign div_eff = (div_reg < 16'd4) ? 16'd4 : div_reg;
   assign par_en  = (parity_reg == PAR_EVEN) || (parity_reg == PAR_ODD);
   assign par_odd = (parity_reg == PAR_ODD);
   assign unused_bits = ^wdata[7:4];

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push(tx_push), .pop(tx_pop),
      .wdata(wdata[DATA_BITS-1:0]), .rdata(tx_head), .full(tx_full),
      .empty(tx_empty), .level(tx_level)
   );

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_push), .pop(rx_pop),
      .wdata(rx_shift_reg), .rdata(rx_head), .full(rx_full),
      .empty(rx_empty), .level(rx_level)
   );

   // Each bit's length is latched at its start so a divisor write only bites at the next boundary.
   assign tx_bit_end   = (tx_cnt_reg == tx_div_reg - 16'd1);
   assign tx_stop_last = (tx_stop_reg == 1'(STOP_BITS - 1));
   assign tx_load      = tx_en_reg && !tx_empty &&
                         ((tx_state_reg == TX_IDLE) ||
                          (tx_state_reg == TX_STOP && tx_bit_end && tx_stop_last));
   assign tx_pop  = tx_load;
   assign tx_push = we && (addr == ADDR_TXDATA);
   assign tx_evt  = (tx_state_reg == TX_STOP) && tx_bit_end && tx_stop_last && tx_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_reg   <= TX_IDLE;
         tx_o           <= 1'b1;
         tx_cnt_reg     <= '0;
         tx_div_reg     <= DIV_RESET;
         tx_shift_reg   <= '0;
         tx_bit_reg     <= '0;
         tx_stop_reg    <= 1'b0;
         tx_par_en_reg  <= 1'b0;
         tx_par_bit_reg <= 1'b0;
      end else if (tx_load) begin
         tx_state_reg   <= TX_START;
         tx_o           <= 1'b0;
         tx_cnt_reg     <= '0;
         tx_div_reg     <= div_eff;
         tx_shift_reg   <= tx_head;
         tx_bit_reg     <= '0;
         tx_stop_reg    <= 1'b0;
         tx_par_en_reg  <= par_en;
         tx_par_bit_reg <= (^tx_head) ^ par_odd;
      end else if (tx_state_reg == TX_IDLE) begin
         tx_o <= 1'b1;
      end else if (!tx_bit_end) begin
         tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end else begin
         tx_cnt_reg <= '0;
         tx_div_reg <= div_eff;
         case (tx_state_reg)
            TX_START: begin
               tx_state_reg <= TX_DATA;
               tx_o         <= tx_shift_reg[0];
            end
            TX_DATA: begin
               if (tx_bit_reg == 3'(DATA_BITS - 1)) begin
                  tx_state_reg <= tx_par_en_reg ? TX_PARITY : TX_STOP;
                  tx_o         <= tx_par_en_reg ? tx_par_bit_reg : 1'b1;
               end else begin
                  tx_bit_reg   <= tx_bit_reg + 3'd1;
                  tx_o         <= tx_shift_reg[1];
                  tx_shift_reg <= tx_shift_reg >> 1;
               end
            end
            TX_PARITY: begin
               tx_state_reg <= TX_STOP;
               tx_o         <= 1'b1;
            end
            TX_STOP: begin
               if (tx_stop_last) tx_state_reg <= TX_IDLE;
               else              tx_stop_reg  <= 1'b1;
            end
            default: tx_state_reg <= TX_IDLE;
         endcase
      end
   end

   assign rx_sample      = (rx_state_reg == RX_START) ? (rx_cnt_reg == (rx_div_reg >> 1) - 16'd1)
                                                      : (rx_cnt_reg == rx_div_reg - 16'd1);
   assign rx_stop_sample = (rx_state_reg == RX_STOP) && rx_sample;
   assign rx_push        = rx_stop_sample && rx_sync2_reg && !rx_par_err_reg;
   assign rx_pop         = ren && (addr == ADDR_RXDATA);
   assign rx_pop_ok      = rx_pop && !rx_empty;
   assign rx_push_ok     = rx_push && (!rx_full || rx_pop_ok);
   assign rx_level_after = 9'(rx_level) + 9'(rx_push_ok) - 9'(rx_pop_ok);
   assign rx_evt         = rx_push_ok && (rx_level_after >= {1'b0, wm_reg});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_sync1_reg   <= 1'b1;
         rx_sync2_reg   <= 1'b1;
         rx_prev_reg    <= 1'b1;
         rx_state_reg   <= RX_IDLE;
         rx_cnt_reg     <= '0;
         rx_div_reg     <= DIV_RESET;
         rx_shift_reg   <= '0;
         rx_bit_reg     <= '0;
         rx_par_en_reg  <= 1'b0;
         rx_par_odd_reg <= 1'b0;
         rx_par_err_reg <= 1'b0;
      end else begin
         rx_sync1_reg <= rx_i;
         rx_sync2_reg <= rx_sync1_reg;
         rx_prev_reg  <= rx_sync2_reg;
         if (rx_state_reg == RX_IDLE) begin
            if (rx_en_reg && rx_prev_reg && !rx_sync2_reg) begin
               rx_state_reg   <= RX_START;
               rx_cnt_reg     <= '0;
               rx_div_reg     <= div_eff;
               rx_bit_reg     <= '0;
               rx_par_en_reg  <= par_en;
               rx_par_odd_reg <= par_odd;
               rx_par_err_reg <= 1'b0;
            end
         end else if (!rx_sample) begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
         end else begin
            rx_cnt_reg <= '0;
            rx_div_reg <= div_eff;
            case (rx_state_reg)
               RX_START: rx_state_reg <= rx_sync2_reg ? RX_IDLE : RX_DATA;
               RX_DATA: begin
                  rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[DATA_BITS-1:1]};
                  if (rx_bit_reg == 3'(DATA_BITS - 1))
                     rx_state_reg <= rx_par_en_reg ? RX_PARITY : RX_STOP;
                  else
                     rx_bit_reg <= rx_bit_reg + 3'd1;
               end
               RX_PARITY: begin
                  rx_par_err_reg <= ((^rx_shift_reg) ^ rx_sync2_reg) != rx_par_odd_reg;
                  rx_state_reg   <= RX_STOP;
               end
               default: rx_state_reg <= RX_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      err_set             = '0;
      err_set[ERR_RX_OVF] = rx_push && rx_full && !rx_pop_ok;
      err_set[ERR_FRAME]  = rx_stop_sample && !rx_sync2_reg;
      err_set[ERR_PARITY] = rx_stop_sample && rx_sync2_reg && rx_par_err_reg;
      err_set[ERR_TX_OVF] = tx_push && tx_full && !tx_pop;
   end

   // W1C masks are applied first so that a same-cycle set event always survives.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_en_reg  <= 1'b0;
         rx_en_reg  <= 1'b0;
         parity_reg <= PAR_NONE;
         wm_reg     <= 8'd1;
         div_reg    <= DIV_RESET;
         ien_reg    <= '0;
         istate_reg <= '0;
         err_reg    <= '0;
      end else begin
         if (we && addr == ADDR_CTRL) begin
            tx_en_reg  <= wdata[0];
            rx_en_reg  <= wdata[1];
            parity_reg <= parity_e'(wdata[3:2]);
            wm_reg     <= wdata[15:8];
            div_reg    <= wdata[31:16];
         end
         if (we && addr == ADDR_INTR_EN) ien_reg <= wdata[2:0];
         err_reg <= (err_reg & ~((we && addr == ADDR_ERR) ? wdata[3:0] : 4'd0)) | err_set;
         istate_reg <= (istate_reg & ~((we && addr == ADDR_INTR_STATE) ? wdata[2:0] : 3'd0))
                     | {|err_set, rx_evt, tx_evt};
      end
   end

   assign intr_tx  = istate_reg[INTR_TX]  & ien_reg[INTR_TX];
   assign intr_rx  = istate_reg[INTR_RX]  & ien_reg[INTR_RX];
   assign intr_err = istate_reg[INTR_ERR] & ien_reg[INTR_ERR];

   always_comb begin
      rdata = '0;
      if (ren) begin
         case (addr)
            ADDR_CTRL:       rdata = {div_reg, wm_reg, 4'd0, parity_reg, rx_en_reg, tx_en_reg};
            ADDR_RXDATA:     rdata = 32'(rx_head);
            ADDR_STATUS:     rdata = {8'd0, 8'(rx_level), 8'(tx_level), 3'd0,
                                      (tx_state_reg != TX_IDLE), rx_empty, rx_full, tx_empty, tx_full};
            ADDR_INTR_EN:    rdata = {29'd0, ien_reg};
            ADDR_INTR_STATE: rdata = {29'd0, istate_reg};
            ADDR_ERR:        rdata = {28'd0, err_reg};
            default:         rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: register reset values, TX framing, parity
// loopback, FIFO overflow, RX frame error, glitch rejection and async reset.
module tb_uart_fifo_core;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ren = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rx_line, tx_o, intr_tx, intr_rx, intr_err;
   logic        rx_bit = 1'b1;
   logic        loop_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   assign rx_line = loop_en ? tx_o : rx_bit;

   always #5 clk_i = ~clk_i;

   uart_fifo_core dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ren(ren), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rx_i(rx_line), .tx_o(tx_o),
      .intr_tx(intr_tx), .intr_rx(intr_rx), .intr_err(intr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk_i);
      we = 1'b1; addr = a; wdata = d;
      @(negedge clk_i);
      we = 1'b0; wdata = 32'h0;
   endtask

   task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk_i);
      ren = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk_i);
      ren = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      reg_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_tx_start(input string tag);
      for (int i = 0; i < 300 && tx_o; i++) @(negedge clk_i);
      check(tag, {31'd0, tx_o}, 32'd0);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx_bit = 1'b0;
      repeat (16) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_bit = b[i];
         repeat (16) @(negedge clk_i);
      end
      rx_bit = stop;
      repeat (16) @(negedge clk_i);
      rx_bit = 1'b1;
      repeat (16) @(negedge clk_i);
   endtask

   initial begin : stim
      logic [9:0]  a5_frame;
      logic [7:0]  lb_bytes [3];
      logic [31:0] d;

      a5_frame = 10'b1_10100101_0;
      lb_bytes[0] = 8'h3C; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h00;

      // reset state
      repeat (3) @(negedge clk_i);
      check("rst_tx_o", {31'd0, tx_o}, 32'd1);
      check("rst_rdata", rdata, 32'd0);
      check("rst_intr", {29'd0, intr_tx, intr_rx, intr_err}, 32'd0);
      rst_ni = 1'b1;
      read_check("rst_ctrl", 8'h00, 32'h0010_0100);
      read_check("rst_status", 8'h0C, 32'h0000_000A);
      read_check("rst_intr_en", 8'h10, 32'h0);
      read_check("rst_intr_state", 8'h14, 32'h0);
      read_check("rst_err", 8'h18, 32'h0);
      read_check("rst_rxdata", 8'h08, 32'h0);
      read_check("unmapped", 8'h1C, 32'h0);

      // single TX frame of 0xA5
      reg_write(8'h00, 32'h0010_0101);
      reg_write(8'h04, 32'h0000_00A5);
      wait_tx_start("a5_start");
      repeat (8) @(negedge clk_i);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("a5_bit%0d", k), {31'd0, tx_o}, {31'd0, a5_frame[k]});
         repeat (16) @(negedge clk_i);
      end
      repeat (8) @(negedge clk_i);
      read_check("a5_intr_state", 8'h14, 32'h1);
      reg_write(8'h10, 32'h1);
      check("a5_intr_tx", {31'd0, intr_tx}, 32'd1);
      reg_write(8'h14, 32'h1);
      check("a5_intr_tx_clr", {31'd0, intr_tx}, 32'd0);
      reg_write(8'h10, 32'h0);

      // even-parity loopback
      loop_en = 1'b1;
      reg_write(8'h00, 32'h0010_0107);
      for (int b = 0; b < 3; b++) begin
         reg_write(8'h04, {24'd0, lb_bytes[b]});
         wait_tx_start($sformatf("lb%0d_start", b));
         repeat (8 + 16 * 9) @(negedge clk_i);
         check($sformatf("lb%0d_parity", b), {31'd0, tx_o}, 32'd0);
         repeat (42) @(negedge clk_i);
         if (b == 0) read_check("lb0_status", 8'h0C, 32'h0001_0002);
         read_check($sformatf("lb%0d_rxdata", b), 8'h08, {24'd0, lb_bytes[b]});
      end
      read_check("lb_err", 8'h18, 32'h0);

      // TX FIFO overflow, then drain through loopback into the RX FIFO
      loop_en = 1'b0;
      reg_write(8'h00, 32'h0010_0100);
      reg_write(8'h14, 32'h7);
      for (int i = 0; i < 9; i++) reg_write(8'h04, 32'h10 + i);
      read_check("ovf_status", 8'h0C, 32'h0000_0809);
      read_check("ovf_err", 8'h18, 32'h8);
      read_check("ovf_intr_state", 8'h14, 32'h4);
      loop_en = 1'b1;
      reg_write(8'h00, 32'h0010_0103);
      repeat (1400) @(negedge clk_i);
      read_check("drain_status", 8'h0C, 32'h0008_0006);
      for (int i = 0; i < 8; i++)
         read_check($sformatf("drain_rx%0d", i), 8'h08, 32'h10 + i);
      read_check("drain_err", 8'h18, 32'h8);
      loop_en = 1'b0;
      reg_write(8'h00, 32'h0010_0102);
      reg_write(8'h18, 32'hF);
      reg_write(8'h14, 32'h7);

      // directly driven good frame
      send_rx(8'h96, 1'b1);
      read_check("rx_good_data", 8'h08, 32'h96);
      read_check("rx_good_err", 8'h18, 32'h0);

      // stop bit low -> frame error
      send_rx(8'h55, 1'b0);
      read_check("ferr_err", 8'h18, 32'h2);
      read_check("ferr_status", 8'h0C, 32'h0000_000A);
      check("ferr_intr_masked", {31'd0, intr_err}, 32'd0);
      reg_write(8'h10, 32'h4);
      check("ferr_intr_err", {31'd0, intr_err}, 32'd1);
      reg_write(8'h18, 32'h2);
      reg_write(8'h14, 32'h4);
      check("ferr_intr_clr", {31'd0, intr_err}, 32'd0);
      read_check("ferr_err_clr", 8'h18, 32'h0);

      // one-cycle glitch
      @(negedge clk_i);
      rx_bit = 1'b0;
      @(negedge clk_i);
      rx_bit = 1'b1;
      repeat (40) @(negedge clk_i);
      read_check("glitch_status", 8'h0C, 32'h0000_000A);
      read_check("glitch_err", 8'h18, 32'h0);

      // reset in the middle of a TX frame
      reg_write(8'h00, 32'h0010_0101);
      reg_write(8'h04, 32'h0);
      wait_tx_start("mid_start");
      repeat (40) @(negedge clk_i);
      check("mid_tx_low", {31'd0, tx_o}, 32'd0);
      #2 rst_ni = 1'b0;
      #1 check("mid_rst_tx_o", {31'd0, tx_o}, 32'd1);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      read_check("mid_rst_status", 8'h0C, 32'h0000_000A);
      read_check("mid_rst_ctrl", 8'h00, 32'h0010_0100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
